// File: rtl/uart_tx_hex_msg_if.sv
// Purpose: groups the message-request and serial-line signals of uart_tx_hex_msg.
// Latency: none (wiring only).
// Backpressure: none; trig is a level sampled every cycle, and busy tells the requester that trig is being ignored.
// Ports: trig (start request), data_in (value to render), uart_txd (serial line),
//        busy (message in progress), msg_done (one-cycle completion pulse).
interface uart_tx_hex_msg_if #(
    parameter int DATA_W = 16
);
    logic              trig;
    logic [DATA_W-1:0] data_in;
    logic              uart_txd;
    logic              busy;
    logic              msg_done;

    // master: the requester, which drives trig/data_in and watches the line.
    modport master (
        output trig,
        output data_in,
        input  uart_txd,
        input  busy,
        input  msg_done
    );

    // slave: the transmitter itself.
    modport slave (
        input  trig,
        input  data_in,
        output uart_txd,
        output busy,
        output msg_done
    );
endinterface

// File: rtl/uart_tx_hex_msg.sv
// Purpose: 8N1 UART transmitter that sends PREFIX, data_in as uppercase hex, then SUFFIX.
// Latency: the line drops one cycle after the start event. The message takes 10*BAUD_DIV*NBYTES cycles, then msg_done pulses.
// Backpressure: none; trig while busy is dropped, and with AUTO_EN a message also starts after GAP_CYC idle cycles.
// Ports: clk, rst_n (synchronous, active-low), bus (uart_tx_hex_msg_if.slave:
//        trig, data_in in; uart_txd, busy, msg_done out).
module uart_tx_hex_msg #(
    parameter int                      CLK_FREQ    = 10_000_000,
    parameter int                      BAUD_RATE   = 115200,
    parameter int                      GAP_TIME_MS = 100,
    parameter int                      AUTO_EN     = 1,
    parameter int                      PREFIX_LEN  = 2,
    parameter logic [8*PREFIX_LEN-1:0] PREFIX      = "V=",
    parameter int                      SUFFIX_LEN  = 2,
    parameter logic [8*SUFFIX_LEN-1:0] SUFFIX      = {8'h0D, 8'h0A},
    parameter int                      DATA_W      = 16
) (
    input logic              clk,
    input logic              rst_n,
    uart_tx_hex_msg_if.slave bus
);
    localparam int BAUD_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int GAP_CYC  = (CLK_FREQ / 1000) * GAP_TIME_MS;
    localparam int HEX_N    = (DATA_W + 3) / 4;
    localparam int HEX_W    = 4 * HEX_N;
    localparam int NBYTES   = PREFIX_LEN + HEX_N + SUFFIX_LEN;

    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int GAP_W  = $clog2(GAP_CYC + 1);
    localparam int BYTE_W = $clog2(NBYTES + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
    localparam logic [BYTE_W-1:0] PRE_END   = BYTE_W'(PREFIX_LEN);
    localparam logic [BYTE_W-1:0] HEX_END   = BYTE_W'(PREFIX_LEN + HEX_N);

    if (BAUD_DIV < 2) begin : g_chk_baud
        $error("uart_tx_hex_msg: BAUD_DIV must be at least 2");
    end
    if (GAP_CYC < 1) begin : g_chk_gap
        $error("uart_tx_hex_msg: GAP_CYC must be at least 1");
    end
    if (PREFIX_LEN < 1 || SUFFIX_LEN < 1) begin : g_chk_len
        $error("uart_tx_hex_msg: PREFIX_LEN and SUFFIX_LEN must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [HEX_W-1:0]  data_q, data_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic       start_evt;
    logic       bit_end;
    logic [7:0] tx_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign start_evt = bus.trig || ((AUTO_EN != 0) && (gap_q == GAP_LAST));
    assign bit_end   = (baud_q == BAUD_LAST);

    // Character for the current byte slot. Strings are stored first-character-in-MSB,
    // and hex digits run from the most significant nibble down.
    always_comb begin
        tx_byte = 8'h00;
        if (byte_q < PRE_END) begin
            tx_byte = 8'(PREFIX >> (8 * (PREFIX_LEN - 1 - int'(byte_q))));
        end else if (byte_q < HEX_END) begin
            tx_byte = hex_char(4'(data_q >> (4 * (PREFIX_LEN + HEX_N - 1 - int'(byte_q)))));
        end else begin
            tx_byte = 8'(SUFFIX >> (8 * (NBYTES - 1 - int'(byte_q))));
        end
    end

    // The txd register is loaded with the level for the bit that starts next cycle.
    // This keeps the line glitch-free and makes each bit exactly BAUD_DIV cycles wide.
    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        data_d  = data_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                busy_d = 1'b0;
                txd_d  = 1'b1;
                if (start_evt) begin
                    state_d = START;
                    gap_d   = '0;
                    data_d  = HEX_W'(bus.data_in);
                    byte_d  = '0;
                    bit_d   = '0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end else if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = tx_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = tx_byte[bit_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_q == BYTE_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        txd_d   = 1'b1;
                    end else begin
                        state_d = START;
                        byte_d  = byte_q + BYTE_W'(1);
                        txd_d   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.uart_txd = txd_q;
    assign bus.busy     = busy_q;
    assign bus.msg_done = done_q;
endmodule

// File: tb/tb_uart_tx_hex_msg.sv
// Bench for uart_tx_hex_msg: instance a is trigger-only with DATA_W=16, and instance b is periodic with DATA_W=10.
// A message-level reference model predicts uart_txd, busy and msg_done every cycle.
// Directed sequences add explicit checks on decoded bytes, timing and abort behaviour.
module tb_uart_tx_hex_msg;
    localparam int BD  = 10;    // (1_000_000 + 50_000) / 100_000
    localparam int GAP = 1000;  // (1_000_000 / 1000) * 1

    bit   clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    bit   chk_on = 1'b0;

    uart_tx_hex_msg_if #(.DATA_W(16)) ifa ();
    uart_tx_hex_msg_if #(.DATA_W(10)) ifb ();

    uart_tx_hex_msg #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .GAP_TIME_MS(1), .AUTO_EN(0), .DATA_W(16)
    ) dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));

    uart_tx_hex_msg #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .GAP_TIME_MS(1), .AUTO_EN(1), .DATA_W(10)
    ) dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    string      HEXS    = "0123456789ABCDEF";
    int         nb[2]   = '{8, 7};
    int         hexn[2] = '{4, 3};
    bit         auto_on[2] = '{1'b0, 1'b1};
    bit         m_act[2];
    bit         m_done[2];
    int         m_off[2];
    int         m_idle[2];
    logic [7:0] m_msg[2][8];

    task automatic render(input int i, input logic [15:0] v);
        string pfx;
        int    k;
        pfx = "V=";
        k   = 0;
        for (int p = 0; p < pfx.len(); p++) begin
            m_msg[i][k] = pfx[p];
            k++;
        end
        for (int j = hexn[i] - 1; j >= 0; j--) begin
            m_msg[i][k] = HEXS[int'((v >> (4 * j)) & 16'hF)];
            k++;
        end
        m_msg[i][k]     = 8'h0D;
        m_msg[i][k + 1] = 8'h0A;
    endtask

    // Called once per rising edge with the inputs that edge samples. It describes the cycle that follows the edge.
    // m_idle counts the idle cycles completed since reset or since the last msg_done cycle.
    task automatic model_step(input int i, input logic rst, input logic trig, input logic [15:0] v);
        if (!rst) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b0;
            m_idle[i] = 0;
            return;
        end
        m_done[i] = 1'b0;
        if (m_act[i]) begin
            m_off[i]++;
            if (m_off[i] == 10 * BD * nb[i]) begin
                m_act[i]  = 1'b0;
                m_done[i] = 1'b1;
                m_idle[i] = 0;
            end
        end else begin
            m_idle[i]++;
            if (trig || (auto_on[i] && m_idle[i] >= GAP)) begin
                m_act[i] = 1'b1;
                m_off[i] = 0;
                render(i, v);
            end
        end
    endtask

    function automatic logic exp_txd(input int i);
        int b, k;
        if (!m_act[i]) return 1'b1;
        b = m_off[i] / (10 * BD);
        k = (m_off[i] / BD) % 10;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_msg[i][b][k - 1];
    endfunction

    always @(posedge clk) begin
        model_step(0, rst_a, ifa.trig, ifa.data_in);
        model_step(1, rst_b, ifb.trig, 16'(ifb.data_in));
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk_eq("a_txd",  32'(ifa.uart_txd), 32'(exp_txd(0)));
            chk_eq("a_busy", 32'(ifa.busy),     32'(m_act[0]));
            chk_eq("a_done", 32'(ifa.msg_done), 32'(m_done[0]));
            chk_eq("b_txd",  32'(ifb.uart_txd), 32'(exp_txd(1)));
            chk_eq("b_busy", 32'(ifb.busy),     32'(m_act[1]));
            chk_eq("b_done", 32'(ifb.msg_done), 32'(m_done[1]));
        end
    end

    // ---------------- instance a: trigger-only ----------------
    task automatic a_single_msg();
        logic [7:0] exp_b[8] = '{8'h56, 8'h3D, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
        logic       bits_s[80];
        logic [7:0] d;
        int         busy_cnt, done_cnt, done_at;
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        @(negedge clk);
        ifa.data_in = 16'h1A2F;
        ifa.trig    = 1'b1;
        for (int j = 1; j <= 900; j++) begin
            @(negedge clk);
            if (j == 1) ifa.trig = 1'b0;
            busy_cnt += int'(ifa.busy);
            if (ifa.msg_done) begin
                done_cnt++;
                done_at = j;
            end
            if (j <= 800 && ((j - 1) % BD) == BD / 2) bits_s[(j - 1) / BD] = ifa.uart_txd;
        end
        chk_eq("t1_busy_cycles", busy_cnt, 800);
        chk_eq("t1_done_count", done_cnt, 1);
        chk_eq("t1_done_at", done_at, 801);
        for (int b = 0; b < 8; b++) begin
            for (int q = 0; q < 8; q++) d[q] = bits_s[b * 10 + 1 + q];
            chk_eq($sformatf("t1_byte%0d", b), 32'(d), 32'(exp_b[b]));
            chk_eq($sformatf("t1_frame%0d", b), {30'd0, bits_s[b * 10 + 9], bits_s[b * 10]}, 32'b10);
        end
    endtask

    task automatic a_trig_while_busy();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        ifa.data_in = 16'($urandom);
        ifa.trig    = 1'b1;
        for (int j = 1; j <= 1000; j++) begin
            @(negedge clk);
            ifa.trig    = (j == 300);
            ifa.data_in = 16'($urandom);
            done_cnt += int'(ifa.msg_done);
        end
        ifa.trig = 1'b0;
        chk_eq("t3_done_count", done_cnt, 1);
    endtask

    task automatic a_trig_held();
        int   starts[4];
        int   ns, low_cnt, done_cnt;
        logic prev_busy;
        ns = 0; low_cnt = 0; done_cnt = 0;
        for (int n = 0; n < 1000 && (m_act[0] || ifa.busy); n++) @(negedge clk);
        repeat (3) @(negedge clk);
        prev_busy = ifa.busy;
        ifa.trig  = 1'b1;
        for (int j = 1; j <= 2000; j++) begin
            @(negedge clk);
            if (ifa.busy && !prev_busy && ns < 4) begin
                starts[ns] = j;
                ns++;
            end
            prev_busy = ifa.busy;
            if (j <= 1602) begin
                low_cnt  += int'(!ifa.busy);
                done_cnt += int'(ifa.msg_done);
            end
        end
        ifa.trig = 1'b0;
        chk_eq("t6_start_count", ns, 3);
        chk_eq("t6_start1", starts[0], 1);
        chk_eq("t6_start2", starts[1], 802);
        chk_eq("t6_busy_low", low_cnt, 2);
        chk_eq("t6_done_count", done_cnt, 2);
        repeat (900) @(negedge clk);
    endtask

    // ---------------- instance b: periodic ----------------
    task automatic b_wait_start(input string tag);
        int start_at;
        start_at = -1;
        for (int j = 1; j <= 1200; j++) begin
            @(negedge clk);
            ifb.data_in = 10'($urandom);
            if (!ifb.uart_txd) begin
                start_at = j;
                break;
            end
        end
        chk_eq(tag, start_at, GAP);
    endtask

    task automatic b_sequence();
        int cnt, n, tgt, ns, done_cnt;
        logic prev_busy;
        // First periodic message carrying 3FF.
        ifb.data_in = 10'h3FF;
        @(negedge clk);
        rst_b = 1'b1;
        cnt = -1;
        for (int j = 1; j <= 1200; j++) begin
            @(negedge clk);
            if (!ifb.uart_txd) begin
                cnt = j;
                break;
            end
        end
        chk_eq("t2_first_start", cnt, GAP);
        ifb.data_in = 10'($urandom);
        cnt = 0;
        while (ifb.busy && cnt < 800) begin
            cnt++;
            @(negedge clk);
            ifb.data_in = 10'($urandom);
        end
        chk_eq("t4_busy_cycles", cnt, 700);
        chk_eq("t4_done", 32'(ifb.msg_done), 32'd1);

        // Free-running periodic traffic with random data and occasional triggers.
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            ifb.data_in = 10'($urandom);
            ifb.trig    = ($urandom_range(0, 1499) == 0);
        end
        ifb.trig = 1'b0;

        // Abort during the data bits of byte 3.
        tgt = 3 * 10 * BD + BD + $urandom_range(0, 8 * BD - 1);
        n = 0;
        while (!(m_act[1] && m_off[1] == tgt) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_eq("t5_reached", 32'(n < 3000), 32'd1);
        rst_b = 1'b0;
        @(negedge clk);
        chk_eq("t5_txd_after_rst", 32'(ifb.uart_txd), 32'd1);
        chk_eq("t5_busy_after_rst", 32'(ifb.busy), 32'd0);
        rst_b = 1'b1;
        b_wait_start("t5_restart");

        // Trigger coincident with gap expiry.
        n = 0;
        while (!(!m_act[1] && m_idle[1] == GAP - 1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_eq("t7_reached", 32'(n < 3000), 32'd1);
        prev_busy = ifb.busy;
        ifb.trig  = 1'b1;
        ns = 0; done_cnt = 0;
        for (int j = 1; j <= 1700; j++) begin
            @(negedge clk);
            ifb.trig = 1'b0;
            if (ifb.busy && !prev_busy) ns++;
            prev_busy = ifb.busy;
            done_cnt += int'(ifb.msg_done);
        end
        chk_eq("t7_start_count", ns, 1);
        chk_eq("t7_done_count", done_cnt, 1);
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.trig = 1'b0;
        ifa.data_in = '0;
        ifb.trig = 1'b0;
        ifb.data_in = '0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        fork
            begin
                @(negedge clk);
                rst_a = 1'b1;
                repeat (5) @(negedge clk);
                a_single_msg();
                a_trig_while_busy();
                for (int c = 0; c < 6000; c++) begin
                    @(negedge clk);
                    ifa.data_in = 16'($urandom);
                    ifa.trig    = ($urandom_range(0, 399) == 0);
                end
                ifa.trig = 1'b0;
                a_trig_held();
            end
            b_sequence();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
